canny_dual_threshold: RTL and testbench

Frame-adaptive double-threshold classifier for the Canny edge path. At every frame end it takes the frame's peak gradient magnitude from the upstream peak tracker and derives a high and a low threshold with an iterative shift-add multiply. It then applies both thresholds to the next frame's gradient-magnitude stream, labelling each pixel none, weak or strong for the downstream hysteresis stage. It also issues a clear pulse so the peak tracker restarts for the new frame.

---
 rtl/canny_dual_threshold.sv | 144 ++++++++++++++
 tb/tb_canny_dual_threshold.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_dual_threshold.sv
// Frame-adaptive double-threshold classifier for the Canny edge path.
// At each accepted frame end the peak magnitude is scaled by HI_NUM/16 and then
// LO_NUM/16 with a 4-step shift-add multiply. The new thresholds take effect in
// one step, and every pixel is labelled none/weak/strong through a 2-stage pipe.
module canny_dual_threshold #(
    parameter int unsigned W      = 20,
    parameter int unsigned HI_NUM = 8,
    parameter int unsigned LO_NUM = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_end,
    input  logic [W-1:0] peak_val,
    input  logic         pix_valid,
    input  logic [W-1:0] pix_mag,
    output logic         out_valid,
    output logic [1:0]   edge_class,
    output logic [W-1:0] thr_high,
    output logic [W-1:0] thr_low,
    output logic         thr_update,
    output logic         busy,
    output logic         peak_clr
);

    localparam logic [3:0] HiBits = 4'(HI_NUM);
    localparam logic [3:0] LoBits = 4'(LO_NUM);

    typedef enum logic [1:0] {StIdle, StCalcHi, StCalcLo, StApply} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] op_q, shadow_hi_q, shadow_lo_q, thr_high_q, thr_low_q;
    logic [W+3:0] acc_q, acc_step;
    logic [1:0]   k_q;
    logic         peak_clr_q, thr_update_q;
    logic         accept, mult_bit;
    logic         s1_valid_q, ge_hi_q, ge_lo_q;
    logic         out_valid_q;
    logic [1:0]   edge_class_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; frame_end outside StIdle is simply not looked at
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (frame_end) state_d = StCalcHi;
            StCalcHi: if (k_q == 2'd0) state_d = StCalcLo;
            StCalcLo: if (k_q == 2'd0) state_d = StApply;
            StApply:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs and one shift-add step (MSB-first over the 4-bit multiplier)
    always_comb begin
        busy     = (state_q != StIdle);
        accept   = (state_q == StIdle) && frame_end;
        mult_bit = 1'b0;
        if (state_q == StCalcHi)      mult_bit = HiBits[k_q];
        else if (state_q == StCalcLo) mult_bit = LoBits[k_q];
        acc_step = {acc_q[W+2:0], 1'b0} + (mult_bit ? {4'b0000, op_q} : '0);
    end

    // Threshold datapath: operand/accumulator/counter, shadows and active thresholds
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= '0;
            acc_q        <= '0;
            k_q          <= 2'd0;
            shadow_hi_q  <= '0;
            shadow_lo_q  <= '0;
            thr_high_q   <= '1;
            thr_low_q    <= '1;
            peak_clr_q   <= 1'b0;
            thr_update_q <= 1'b0;
        end else begin
            peak_clr_q   <= accept;
            thr_update_q <= (state_q == StApply);
            case (state_q)
                StIdle: begin
                    if (frame_end) begin
                        op_q  <= peak_val;
                        acc_q <= '0;
                        k_q   <= 2'd3;
                    end
                end
                StCalcHi: begin
                    if (k_q == 2'd0) begin
                        // High result becomes the operand of the low multiply
                        shadow_hi_q <= acc_step[W+3:4];
                        op_q        <= acc_step[W+3:4];
                        acc_q       <= '0;
                        k_q         <= 2'd3;
                    end else begin
                        acc_q <= acc_step;
                        k_q   <= k_q - 2'd1;
                    end
                end
                StCalcLo: begin
                    if (k_q == 2'd0) begin
                        shadow_lo_q <= acc_step[W+3:4];
                    end else begin
                        acc_q <= acc_step;
                        k_q   <= k_q - 2'd1;
                    end
                end
                StApply: begin
                    thr_high_q <= shadow_hi_q;
                    thr_low_q  <= shadow_lo_q;
                end
                default: ;
            endcase
        end
    end

    // Classifier pipeline, independent of the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            ge_hi_q      <= 1'b0;
            ge_lo_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            edge_class_q <= 2'd0;
        end else begin
            s1_valid_q   <= pix_valid;
            ge_hi_q      <= (pix_mag >= thr_high_q);
            ge_lo_q      <= (pix_mag >= thr_low_q);
            out_valid_q  <= s1_valid_q;
            edge_class_q <= ge_hi_q ? 2'd2 : (ge_lo_q ? 2'd1 : 2'd0);
        end
    end

    assign out_valid  = out_valid_q;
    assign edge_class = edge_class_q;
    assign thr_high   = thr_high_q;
    assign thr_low    = thr_low_q;
    assign thr_update = thr_update_q;
    assign peak_clr   = peak_clr_q;

endmodule

// File: tb/tb_canny_dual_threshold.sv
// Scoreboard bench for canny_dual_threshold. Two instances share the stimulus:
// one with default ratios and one with HI_NUM = 15. The reference model keeps the
// list of accepted frame ends and derives every expected output from it arithmetically.
module tb_canny_dual_threshold;

    localparam int W = 20;
    localparam logic [W-1:0] ALL1 = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_end;
    logic [W-1:0] peak_val;
    logic         pix_valid;
    logic [W-1:0] pix_mag;

    logic         ova, tua, bua, pca, ovb, tub, bub, pcb;
    logic [1:0]   eca, ecb;
    logic [W-1:0] tha, tla, thb, tlb;

    always #5 clk = ~clk;

    canny_dual_threshold #(.W(W), .HI_NUM(8), .LO_NUM(6)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .frame_end  (frame_end),
        .peak_val   (peak_val),
        .pix_valid  (pix_valid),
        .pix_mag    (pix_mag),
        .out_valid  (ova),
        .edge_class (eca),
        .thr_high   (tha),
        .thr_low    (tla),
        .thr_update (tua),
        .busy       (bua),
        .peak_clr   (pca)
    );

    canny_dual_threshold #(.W(W), .HI_NUM(15), .LO_NUM(6)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .frame_end  (frame_end),
        .peak_val   (peak_val),
        .pix_valid  (pix_valid),
        .pix_mag    (pix_mag),
        .out_valid  (ovb),
        .edge_class (ecb),
        .thr_high   (thb),
        .thr_low    (tlb),
        .thr_update (tub),
        .busy       (bub),
        .peak_clr   (pcb)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit mon_en   = 1'b0;

    // Reference model state: accepted frame ends and their peaks
    int           acc_edge[$];
    logic [W-1:0] acc_peak[$];
    logic [1:0]   qa[$];
    logic [1:0]   qb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] scale(input logic [W-1:0] v, input int num);
        longint p;
        p = longint'(v) * num;
        return W'(p / 16);
    endfunction

    // Threshold in effect for a pixel sampled at edge x
    function automatic logic [W-1:0] thr_at(input int x, input int hn, input int ln,
                                            input bit lo_sel);
        logic [W-1:0] h;
        for (int i = acc_edge.size() - 1; i >= 0; i--) begin
            if (acc_edge[i] + 10 <= x) begin
                h = scale(acc_peak[i], hn);
                return lo_sel ? scale(h, ln) : h;
            end
        end
        return ALL1;
    endfunction

    function automatic bit ev_clr(input int n);
        foreach (acc_edge[i]) if (acc_edge[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ev_busy(input int n);
        foreach (acc_edge[i]) if (n >= acc_edge[i] && n <= acc_edge[i] + 8) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ev_upd(input int n);
        foreach (acc_edge[i]) if (acc_edge[i] + 9 == n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] cls(input logic [W-1:0] m, input logic [W-1:0] h,
                                       input logic [W-1:0] l);
        if (m >= h) return 2'd2;
        if (m >= l) return 2'd1;
        return 2'd0;
    endfunction

    // Drive one cycle of inputs, record expectations, advance past the edge
    task automatic step(input logic fe, input logic [W-1:0] pk, input logic pv,
                        input logic [W-1:0] mg);
        int e;
        e = edge_n + 1;
        frame_end = fe;
        peak_val  = pk;
        pix_valid = pv;
        pix_mag   = mg;
        if (!rst) begin
            if (pv) begin
                qa.push_back(cls(mg, thr_at(e, 8, 6, 1'b0), thr_at(e, 8, 6, 1'b1)));
                qb.push_back(cls(mg, thr_at(e, 15, 6, 1'b0), thr_at(e, 15, 6, 1'b1)));
            end
            if (fe && (acc_edge.size() == 0 || e >= acc_edge[$] + 10)) begin
                acc_edge.push_back(e);
                acc_peak.push_back(pk);
            end
        end
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic pix(input logic [W-1:0] m);
        step(1'b0, '0, 1'b1, m);
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        rst    = 1'b1;
        repeat (n) step(1'b0, '0, 1'b0, '0);
        acc_edge.delete();
        acc_peak.delete();
        qa.delete();
        qb.delete();
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    // Monitor: per-cycle control/threshold checks and scoreboard pops
    always @(negedge clk) begin
        int n;
        logic [1:0] e;
        if (mon_en) begin
            n = edge_n;
            chk("a_thr_high", tha, thr_at(n + 1, 8, 6, 1'b0));
            chk("a_thr_low", tla, thr_at(n + 1, 8, 6, 1'b1));
            chk("b_thr_high", thb, thr_at(n + 1, 15, 6, 1'b0));
            chk("b_thr_low", tlb, thr_at(n + 1, 15, 6, 1'b1));
            chk("a_thr_update", tua, ev_upd(n));
            chk("a_peak_clr", pca, ev_clr(n));
            chk("a_busy", bua, ev_busy(n));
            chk("b_thr_update", tub, ev_upd(n));
            chk("b_peak_clr", pcb, ev_clr(n));
            chk("b_busy", bub, ev_busy(n));
            if (ova) begin
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_out actual=%0d required=none", eca);
                end else begin
                    e = qa.pop_front();
                    chk("a_edge_class", eca, e);
                end
            end
            if (ovb) begin
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_out actual=%0d required=none", ecb);
                end else begin
                    e = qb.pop_front();
                    chk("b_edge_class", ecb, e);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] base, pk, mg;
        rst       = 1'b1;
        frame_end = 1'b0;
        peak_val  = '0;
        pix_valid = 1'b0;
        pix_mag   = '0;
        do_reset(3);

        // Reset thresholds: only all-ones reaches strong
        pix(20'h00000);
        pix(20'h12345);
        pix(20'hFFFFE);
        pix(20'hFFFFF);
        idle(3);

        // Default ratios on peak 1600
        step(1'b1, 20'd1600, 1'b0, '0);
        idle(10);
        chk("a_thr_high_1600", tha, 800);
        chk("a_thr_low_1600", tla, 300);
        chk("b_thr_high_1600", thb, 1500);
        chk("b_thr_low_1600", tlb, 562);
        pix(20'd799);
        pix(20'd800);
        pix(20'd299);
        pix(20'd300);
        idle(3);

        // Full-scale peak
        step(1'b1, 20'hFFFFF, 1'b0, '0);
        idle(10);
        chk("b_thr_high_max", thb, 20'hEFFFF);
        chk("b_thr_low_max", tlb, 20'h59FFF);
        chk("a_thr_high_max", tha, 20'h7FFFF);
        pix(20'hEFFFE);
        pix(20'hEFFFF);
        idle(3);

        // Zero peak: everything strong
        step(1'b1, 20'd0, 1'b0, '0);
        idle(10);
        chk("a_thr_high_zero", tha, 0);
        chk("b_thr_low_zero", tlb, 0);
        pix(20'd0);
        pix(20'd1);
        pix(20'hABCDE);
        idle(3);

        // frame_end at E0+4 ignored, at E0+10 accepted
        step(1'b1, 20'd1600, 1'b1, 20'd5);
        idle(3);
        step(1'b1, 20'd5000, 1'b1, 20'd900);
        idle(5);
        step(1'b1, 20'd3200, 1'b1, 20'd1000);
        idle(10);
        chk("a_thr_high_3200", tha, 1600);
        idle(2);

        // Reset mid-computation
        step(1'b1, 20'd1600, 1'b0, '0);
        idle(4);
        do_reset(1);
        idle(11);
        chk("a_thr_high_after_rst", tha, ALL1);
        chk("a_busy_after_rst", bua, 0);
        pix(20'h10);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            pk = ($urandom % 4 == 0) ? 20'hFFFFF : W'($urandom);
            case ($urandom % 3)
                0: begin
                    base = thr_at(edge_n + 1, 8, 6, 1'b0);
                    mg   = base + W'($urandom_range(0, 2)) - 20'd1;
                end
                1: begin
                    base = thr_at(edge_n + 1, 8, 6, 1'b1);
                    mg   = base + W'($urandom_range(0, 2)) - 20'd1;
                end
                default: mg = W'($urandom);
            endcase
            step(($urandom % 12) == 0, pk, ($urandom % 4) != 0, mg);
        end

        idle(4);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
